// File: rtl/multiword_add_seq.sv
// Multi-word sequential adder/subtractor.
// Operands of WORDS 16-bit chunks are added one chunk per cycle through a single
// shared 16-bit two-level carry-lookahead stage. The chunk carry is kept in a
// register between cycles. There is a simple valid/ready handshake on each side,
// and only one request is in flight at a time.
module multiword_add_seq #(
   parameter int unsigned WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*WORDS-1:0]   a,
   input  logic [16*WORDS-1:0]   b,
   input  logic                  sub,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WORDS-1:0]   sum,
   output logic                  cout,
   output logic                  ovf,
   output logic                  busy
);

   localparam int unsigned N  = 16 * WORDS;
   localparam int unsigned KW = $clog2(WORDS + 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic          carry_q, carry_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [N-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   // Current chunk operands and adder results
   logic [15:0]   chunk_a;
   logic [15:0]   chunk_b;
   logic [15:0]   chunk_sum;
   logic [16:0]   bit_c;       // bit_c[i] is the carry into bit i; bit_c[16] is chunk carry-out
   logic [15:0]   g_bit;
   logic [15:0]   p_bit;
   logic [3:0]    g_grp;
   logic [3:0]    p_grp;
   logic [3:0]    c_grp;       // carries out of groups 0..3

   // Four-bit lookahead: returns carries out of bits 0..3 given generate,
   // propagate and the carry into bit 0.
   function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                       input logic c0);
      logic [3:0] c;
      c[0] = g[0] | (p[0] & c0);
      c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return c;
   endfunction

   // Select chunk k of the latched operands
   always_comb begin
      chunk_a = '0;
      chunk_b = '0;
      for (int w = 0; w < int'(WORDS); w++) begin
         if (k_q == KW'(w)) begin
            chunk_a = a_q[16*w +: 16];
            chunk_b = b_q[16*w +: 16];
         end
      end
   end

   // Shared 16-bit two-level carry-lookahead adder
   always_comb begin
      logic [3:0] grp_c;
      logic [3:0] grp_cin;
      g_bit = chunk_a & chunk_b;
      p_bit = chunk_a ^ chunk_b;
      for (int j = 0; j < 4; j++) begin
         grp_c    = cla4(g_bit[4*j +: 4], p_bit[4*j +: 4], 1'b0);
         g_grp[j] = grp_c[3];
         p_grp[j] = &p_bit[4*j +: 4];
      end
      c_grp      = cla4(g_grp, p_grp, carry_q);
      grp_cin    = {c_grp[2:0], carry_q};
      bit_c      = '0;
      for (int j = 0; j < 4; j++) begin
         grp_c                = cla4(g_bit[4*j +: 4], p_bit[4*j +: 4], grp_cin[j]);
         bit_c[4*j]           = grp_cin[j];
         bit_c[4*j+1 +: 3]    = grp_c[2:0];
      end
      bit_c[16] = c_grp[3];
      chunk_sum = p_bit ^ bit_c[15:0];
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = cin;
               k_d     = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            for (int w = 0; w < int'(WORDS); w++) begin
               if (k_q == KW'(w)) begin
                  sum_d[16*w +: 16] = chunk_sum;
               end
            end
            carry_d = bit_c[16];
            k_d     = k_q + KW'(1);
            if (k_q == KW'(WORDS - 1)) begin
               // Top chunk: bit 15 of this chunk is bit N-1 of the result
               cout_d  = bit_c[16];
               ovf_d   = bit_c[15] ^ bit_c[16];
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         k_q     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Handshake and result outputs
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      busy      = (state_q != StIdle);
      sum       = sum_q;
      cout      = cout_q;
      ovf       = ovf_q;
   end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq with WORDS=4.
module tb_multiword_add_seq;

   localparam int unsigned WORDS = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a_i;
   logic [63:0] b_i;
   logic        sub_i;
   logic        cin_i;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] sum;
   logic        cout;
   logic        ovf;
   logic        busy;

   int tests;
   int fails;
   int lat;

   multiword_add_seq #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .sub       (sub_i),
      .cin       (cin_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait for IDLE, present one request for exactly one edge, then scramble inputs.
   task automatic start_req(input logic [63:0] ta, input logic [63:0] tbv,
                            input logic ts, input logic tc);
      int i;
      i = 0;
      while (!in_ready && i < 20) begin
         @(posedge clk); #1;
         i++;
      end
      check("accept_ready", 64'(in_ready), 64'd1);
      a_i      = ta;
      b_i      = tbv;
      sub_i    = ts;
      cin_i    = tc;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_i      = ~ta;
      b_i      = ~tbv;
      sub_i    = ~ts;
      cin_i    = ~tc;
   endtask

   // Count edges after acceptance until out_valid, bounded.
   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("ready_after_release", 64'(in_ready), 64'd1);
   endtask

   task automatic full_vec(input string tag, input logic [63:0] ta, input logic [63:0] tbv,
                           input logic ts, input logic tc, input logic [63:0] es,
                           input logic ec, input logic eo);
      start_req(ta, tbv, ts, tc);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
      wait_done(lat);
      check({tag, "_latency"}, 64'(lat), 64'd4);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, 64'(cout), 64'(ec));
      check({tag, "_ovf"}, 64'(ovf), 64'(eo));
      release_result();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tests     = 0;
      fails     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_i       = '0;
      b_i       = '0;
      sub_i     = 1'b0;
      cin_i     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sum", sum, 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      rst = 1'b0;

      // Carry across a chunk boundary
      full_vec("carry_chunk", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0, 1'b0);
      // Full wrap with carry out
      full_vec("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h0, 1'b1, 1'b0);
      // Signed overflow
      full_vec("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
      // Subtraction with borrow
      full_vec("sub", 64'd5, 64'd7, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

      // Mixed pattern with carry-in, held under back-pressure
      start_req(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
      wait_done(lat);
      check("bp_latency", 64'(lat), 64'd4);
      for (int i = 0; i < 3; i++) begin
         in_valid = ~in_valid;
         a_i      = a_i + 64'h1111;
         b_i      = ~b_i;
         @(posedge clk); #1;
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_sum", sum, 64'h2222_2222_2222_2212);
         check("bp_cout", 64'(cout), 64'd0);
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      release_result();
      check("idle_out_valid", 64'(out_valid), 64'd0);
      check("idle_sum_hold", sum, 64'h2222_2222_2222_2212);

      // Reset in the second RUN cycle aborts the operation
      start_req(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_sum", sum, 64'd0);
      full_vec("post_abort", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
